// File: rtl/jesd_loopback_pattern_checker_if.sv
// jesd_loopback_pattern_checker_if
//   Groups the checker's control, sample-bus and status signals.
//   master : drives enable/clear/adc_valid/adc_data, observes status (bench / upstream)
//   slave  : the checker itself
//   Signals: enable, clear, adc_valid, adc_data[NUM_CH*SAMPLES_PER_CH*DMA_NP],
//            locked, err_beat, err_count[32], ch_err[NUM_CH]
interface jesd_loopback_pattern_checker_if #(
  parameter int NUM_CH         = 4,
  parameter int SAMPLES_PER_CH = 4,
  parameter int DMA_NP         = 16
);
  logic                                    enable;
  logic                                    clear;
  logic                                    adc_valid;
  logic [NUM_CH*SAMPLES_PER_CH*DMA_NP-1:0] adc_data;
  logic                                    locked;
  logic                                    err_beat;
  logic [31:0]                             err_count;
  logic [NUM_CH-1:0]                       ch_err;

  modport master (
    output enable, clear, adc_valid, adc_data,
    input  locked, err_beat, err_count, ch_err
  );

  modport slave (
    input  enable, clear, adc_valid, adc_data,
    output locked, err_beat, err_count, ch_err
  );
endinterface

// File: rtl/jesd_loopback_pattern_checker.sv
// jesd_loopback_pattern_checker
//   Tracks the JESD loopback test pattern on received ADC beats, locks onto it
//   from channel 0, then flags beats that deviate from the expected pattern.
//   Ports:
//     device_clk  sole clock, rising edge
//     reset       asynchronous, active-high
//     bus         jesd_loopback_pattern_checker_if.slave
//                 (enable, clear, adc_valid, adc_data in; locked, err_beat,
//                  err_count, ch_err out)
//   Optional feature macro: JESD_PATTERN_CHECKER_CH_ERR_EN
//     defined   -> sticky per-channel mismatch flags on ch_err
//     undefined -> ch_err tied to zero, no per-channel flag registers

// Per-channel comparator: one channel's beat against tracker value c.
module jesd_lpc_lane #(
  parameter int CH  = 0,
  parameter int SPC = 4,
  parameter int NP  = 16
) (
  input  logic [SPC*NP-1:0] data,
  input  logic [8:0]        c,
  output logic              mis
);
  localparam logic [3:0] ID = 4'(CH);

  always_comb begin
    mis = 1'b0;
    for (int j = 0; j < SPC; j++) begin
      if (!c[8]) begin
        // phase 0: channel id replicated in every nibble
        if (data[j*NP +: NP] != {4{ID}}) mis = 1'b1;
      end else begin
        // phase 1: id in top nibble, running count in low byte; [11:8] free
        if ((data[j*NP+12 +: 4] != ID) ||
            (data[j*NP +: 8] != (c[7:0] + 8'(j)))) mis = 1'b1;
      end
    end
  end
endmodule

module jesd_loopback_pattern_checker #(
  parameter int NUM_CH         = 4,
  parameter int SAMPLES_PER_CH = 4,
  parameter int DMA_NP         = 16,
  parameter int LOSS_THRESH    = 4
) (
  input logic                            device_clk,
  input logic                            reset,
  jesd_loopback_pattern_checker_if.slave bus
);
  localparam int LANE_W = SAMPLES_PER_CH*DMA_NP;

  typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [8:0]        c_q, c_d;
  logic [3:0]        run_q, run_d;
  logic [NUM_CH-1:0] ch_mis;
  logic              cmp_en, bad, seed_ok;
  logic [7:0]        seed_b;
  logic              err_beat_q;
  logic [31:0]       err_count_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    jesd_lpc_lane #(.CH(i), .SPC(SAMPLES_PER_CH), .NP(DMA_NP)) u_lane (
      .data (bus.adc_data[i*LANE_W +: LANE_W]),
      .c    (c_q),
      .mis  (ch_mis[i])
    );
  end

  // Seed detection on channel 0: a phase-1 run of b, b+1, ... with id nibble 0.
  assign seed_b = bus.adc_data[7:0];

  always_comb begin
    seed_ok = 1'b1;
    for (int j = 0; j < SAMPLES_PER_CH; j++) begin
      if ((bus.adc_data[j*DMA_NP+12 +: 4] != 4'h0) ||
          (bus.adc_data[j*DMA_NP +: 8] != (seed_b + 8'(j)))) seed_ok = 1'b0;
    end
  end

  assign cmp_en = bus.enable && bus.adc_valid && (state_q == LOCKED);
  assign bad    = cmp_en && (|ch_mis);

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    run_d   = run_q;
    if (!bus.enable) begin
      state_d = SEARCH;
      run_d   = '0;
    end else if (bus.adc_valid) begin
      case (state_q)
        SEARCH: begin
          if (seed_ok) begin
            // the seed beat itself is consumed, so resume one beat later
            state_d = LOCKED;
            c_d     = {1'b1, seed_b} + 9'(SAMPLES_PER_CH);
            run_d   = '0;
          end
        end
        LOCKED: begin
          c_d = c_q + 9'(SAMPLES_PER_CH);
          if (bad) begin
            if (run_q == 4'(LOSS_THRESH-1)) begin
              state_d = SEARCH;
              run_d   = '0;
            end else begin
              run_d = run_q + 4'd1;
            end
          end else begin
            run_d = '0;
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  always_ff @(posedge device_clk or posedge reset) begin
    if (reset) begin
      state_q     <= SEARCH;
      c_q         <= '0;
      run_q       <= '0;
      err_beat_q  <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q    <= state_d;
      c_q        <= c_d;
      run_q      <= run_d;
      err_beat_q <= bad;
      if (bus.clear)
        err_count_q <= '0;
      else if (bad && (err_count_q != '1))
        err_count_q <= err_count_q + 32'd1;
    end
  end

  assign bus.locked    = (state_q == LOCKED);
  assign bus.err_beat  = err_beat_q;
  assign bus.err_count = err_count_q;

`ifdef JESD_PATTERN_CHECKER_CH_ERR_EN
  logic [NUM_CH-1:0] ch_err_q;

  always_ff @(posedge device_clk or posedge reset) begin
    if (reset)
      ch_err_q <= '0;
    else if (bus.clear)
      ch_err_q <= '0;
    else if (cmp_en)
      ch_err_q <= ch_err_q | ch_mis;
  end

  assign bus.ch_err = ch_err_q;
`else
  assign bus.ch_err = '0;
`endif
endmodule
